jtag_to_onchipmem_copy_sequencer: RTL
=====================================

// Module: jtag_to_onchipmem_copy_sequencer
// PURPOSE
//  Block-copy controller for the JTAG-to-on-chip-memory subsystem. The host
//  sets cfg_src/cfg_dst/cfg_len through PIO registers, then raises the
//  start_transfer PIO bit. This block sees the rising edge and copies cfg_len
//  words from src to dst through an Avalon-MM master port on the on-chip memory.
//  busy/done/words_done feed back to a status PIO that the host polls.
// PARAMETERS
//  ADDR_W  10  word-address width of the on-chip memory
//  DATA_W  32  memory data width
//  LEN_W   11  width of the length field (max copy = 2^LEN_W-1 words)
// PORTS
//  clk            in   1       system clock
//  reset          in   1       asynchronous, active-high reset
//  start          in   1       start_transfer PIO bit; only a rising edge triggers a copy
//  cfg_src        in   ADDR_W  source word base, sampled on the start edge
//  cfg_dst        in   ADDR_W  destination word base, sampled on the start edge
//  cfg_len        in   LEN_W   word count, sampled on the start edge
//  mem_address    out  ADDR_W  Avalon-MM word address
//  mem_read       out  1       Avalon-MM read request
//  mem_write      out  1       Avalon-MM write request
//  mem_writedata  out  DATA_W  Avalon-MM write data
//  mem_readdata   in   DATA_W  read data; valid exactly 1 cycle after read accepted
//  mem_waitrequest in  1       slave stall; request held until low
//  busy           out  1       copy in progress
//  done           out  1       sticky: last copy completed; cleared by next accepted start
//  words_done     out  LEN_W   words written so far in the current/last copy
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, start_q=0. Reset mid-copy aborts at once.
//   No request stays asserted, and done is not set.
//  Edge detect: start_q <= start each cycle; go = start & ~start_q.
//   A level held high never retriggers. Edges outside IDLE are ignored, not queued.
//  FSM states: IDLE, RD, LAT, WR.
//   IDLE: busy=0. On go with cfg_len==0: done<=1, words_done<=0, stay in IDLE.
//    On go with cfg_len!=0: latch src/dst/len, cnt<=0, done<=0,
//    words_done<=0, busy<=1, next state RD.
//   RD: mem_read=1, mem_address=src+cnt. Hold while mem_waitrequest=1.
//    When accepted (waitrequest=0), go to LAT.
//   LAT: capture mem_readdata into buf; go to WR.
//   WR: mem_write=1, mem_address=dst+cnt, mem_writedata=buf.
//    Hold while waitrequest=1. When accepted: cnt++, words_done++.
//    If cnt+1==len: done<=1, busy<=0, go to IDLE. Otherwise go to RD.
//  Avalon master rules:
//   mem_read and mem_write are never high together.
//   address/data stay stable while waitrequest=1.
//   mem_address/mem_writedata are 0 whenever no request is active.
//  Address arithmetic is modulo 2^ADDR_W: ranges wrap past the top word to 0.
//   Overlapping src/dst is not checked; copy order is ascending.
//  Timing: the go edge is sampled at clock edge E0. With zero waitstates each
//   word takes 3 cycles, so done rises at E0+3*len. Each waitrequest cycle adds 1.
//  All outputs are registered except mem_* (decoded from state, cnt and latched bases).
// TESTING
//  1 Assert reset for 3 cycles mid-stream -> every output is 0 and state=IDLE.
//  2 src=0x010, dst=0x100, len=4, mem[0x10..0x13]=A0..A3, no wait
//    -> mem[0x100..0x103]=A0..A3, done at E0+12, words_done=4.
//  3 Same copy, slave stalls 2 cycles on every access
//    -> same data, done at E0+28, request signals stable during stalls.
//  4 cfg_len=0 -> done=1 at E0, busy stays 0, no mem_read or mem_write.
//  5 src=0x3FE, dst=0x200, len=4, start held high, plus an extra pulse while busy
//    -> reads 0x3FE, 0x3FF, 0x000, 0x001, exactly one copy runs.
//  6 reset after 2 words written -> mem_read/mem_write go to 0 asynchronously
//    and done=0. A new start then completes a full copy normally.

Source files
------------

// File: rtl/jtag_to_onchipmem_copy_sequencer.sv
// ---------------------------------------------------------------------------
// jtag_to_onchipmem_copy_sequencer
// Block-copy engine for the JTAG-to-on-chip-memory path. A rising edge on the
// start PIO bit latches src/dst/len and copies len words, one read followed by
// one write per word, through an Avalon-MM master. busy/done/words_done are
// registered status bits polled by the host through a status PIO.
// ---------------------------------------------------------------------------
module jtag_to_onchipmem_copy_sequencer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_waitrequest,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done
);

    // IDLE waits for a start edge; RD issues the read; LAT captures the
    // read data that the memory returns one cycle after acceptance; WR
    // writes the captured word to the destination.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        LAT  = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t             state_r;
    logic               start_q_r;
    logic [ADDR_W-1:0]  src_r;
    logic [ADDR_W-1:0]  dst_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   cnt_r;
    logic [DATA_W-1:0]  buf_r;
    logic               busy_r;
    logic               done_r;
    logic [LEN_W-1:0]   words_done_r;

    logic               go_s;
    logic               last_s;
    logic [ADDR_W-1:0]  rd_addr_s;
    logic [ADDR_W-1:0]  wr_addr_s;

    // Word address of element 'offset' of a range starting at 'base'.
    // The sum is truncated to ADDR_W, so ranges wrap past the top word to 0.
    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ADDR_W-1:0] base,
        input logic [LEN_W-1:0]  offset
    );
        logic [ADDR_W-1:0] off_trunc;
        off_trunc = ADDR_W'(offset);
        return base + off_trunc;
    endfunction

    // Only a rising edge of the PIO bit counts; a held level never retriggers.
    assign go_s      = start & ~start_q_r;
    // The word being written is the final one of the copy.
    assign last_s    = (cnt_r == (len_r - LEN_W'(1)));
    assign rd_addr_s = word_addr(src_r, cnt_r);
    assign wr_addr_s = word_addr(dst_r, cnt_r);

    // Sequencer state, latched configuration and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            start_q_r    <= 1'b0;
            src_r        <= {ADDR_W{1'b0}};
            dst_r        <= {ADDR_W{1'b0}};
            len_r        <= {LEN_W{1'b0}};
            cnt_r        <= {LEN_W{1'b0}};
            buf_r        <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            words_done_r <= {LEN_W{1'b0}};
        end else begin
            start_q_r <= start;
            case (state_r)
                IDLE: begin
                    if (go_s) begin
                        words_done_r <= {LEN_W{1'b0}};
                        if (cfg_len == {LEN_W{1'b0}}) begin
                            // Empty copy completes on the start edge itself.
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            src_r   <= cfg_src;
                            dst_r   <= cfg_dst;
                            len_r   <= cfg_len;
                            cnt_r   <= {LEN_W{1'b0}};
                            done_r  <= 1'b0;
                            busy_r  <= 1'b1;
                            state_r <= RD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    if (!mem_waitrequest) begin
                        state_r <= LAT;
                    end else begin
                        state_r <= RD;
                    end
                end
                LAT: begin
                    buf_r   <= mem_readdata;
                    state_r <= WR;
                end
                WR: begin
                    if (!mem_waitrequest) begin
                        cnt_r        <= cnt_r + LEN_W'(1);
                        words_done_r <= words_done_r + LEN_W'(1);
                        if (last_s) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            state_r <= RD;
                        end
                    end else begin
                        state_r <= WR;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Avalon request decode: request, address and data come straight from
    // the state and latched bases, so they stay put through waitrequest and
    // drop to zero the moment reset forces the state back to IDLE.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = {ADDR_W{1'b0}};
        mem_writedata = {DATA_W{1'b0}};
        case (state_r)
            RD: begin
                mem_read    = 1'b1;
                mem_address = rd_addr_s;
            end
            WR: begin
                mem_write     = 1'b1;
                mem_address   = wr_addr_s;
                mem_writedata = buf_r;
            end
            default: begin
                mem_read      = 1'b0;
                mem_write     = 1'b0;
                mem_address   = {ADDR_W{1'b0}};
                mem_writedata = {DATA_W{1'b0}};
            end
        endcase
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign words_done = words_done_r;

endmodule
